adc_freq_meter: RTL and testbench

Receive-side counterpart of the DDS generator. It takes unsigned 10-bit ADC samples and detects rising crossings with a hysteresis comparator. It counts those crossings over a gate of 2^GATE_LOG2 clocks and reports the frequency as a 32-bit frequency control word, scaled exactly like the DDS Fcword input. The block sits after the ADC capture path and supports loopback checks: DDS Fcword in, ADC, meter, Fcword estimate out.

---
 rtl/adc_dds_pkg.sv | 21 ++
 rtl/adc_freq_meter_if.sv | 34 +++
 rtl/adc_freq_meter_hyst_cmp.sv | 38 +++
 rtl/adc_freq_meter.sv | 105 ++++++++++
 tb/tb_adc_freq_meter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/adc_dds_pkg.sv
// Shared DDS / frequency meter definitions.
// Holds default widths, FSM state encoding and count-to-Fcword helper.
package adc_dds_pkg;

  localparam int FCW_W  = 32;
  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [FCW_W-1:0] cnt2fcw(
    input logic [FCW_W-1:0] cnt,
    input int unsigned      sh
  );
    return cnt << sh;
  endfunction

endpackage

// File: rtl/adc_freq_meter_if.sv
// Control, sample and result bundle of the ADC frequency meter.
// master drives sample/control, slave is the meter.
interface adc_freq_meter_if #(
  parameter int DATA_W    = adc_dds_pkg::DATA_W,
  parameter int FCW_W     = adc_dds_pkg::FCW_W,
  parameter int GATE_LOG2 = 20
);
  logic                 start;
  logic                 cont;
  logic [DATA_W-1:0]    adc_data;
  logic                 adc_valid;
  logic [DATA_W-1:0]    thr_hi;
  logic [DATA_W-1:0]    thr_lo;
  logic [FCW_W-1:0]     fcword_est;
  logic [GATE_LOG2-1:0] edge_cnt;
  logic                 meas_valid;
  logic                 busy;
  logic                 sig_lost;
  logic                 cfg_err;

  modport master (
    output start, cont, adc_data, adc_valid,
    output thr_hi, thr_lo,
    input  fcword_est, edge_cnt, meas_valid,
    input  busy, sig_lost, cfg_err
  );

  modport slave (
    input  start, cont, adc_data, adc_valid,
    input  thr_hi, thr_lo,
    output fcword_est, edge_cnt, meas_valid,
    output busy, sig_lost, cfg_err
  );
endinterface

// File: rtl/adc_freq_meter_hyst_cmp.sv
// Hysteresis comparator: emits one rise event per low-to-high switch.
// Inverted thresholds collapse the low threshold onto the high one.
module hyst_cmp #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  output logic              rise,
  output logic              cfg_err
);

  logic              hi;
  logic              bad;
  logic [DATA_W-1:0] lo_eff;

  assign bad    = thr_lo > thr_hi;
  assign lo_eff = bad ? thr_hi : thr_lo;
  assign rise   = adc_valid && !hi && (adc_data >= thr_hi);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (bad)
        cfg_err <= 1'b1;
      if (rise)
        hi <= 1'b1;
      else if (adc_valid && hi && (adc_data <= lo_eff))
        hi <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_freq_meter.sv
// Gated rising-crossing counter reporting a DDS-scaled frequency word.
// ADC_FMETER_AVG_EN enables a 4-gate moving sum on fcword_est.
module adc_freq_meter #(
  parameter int DATA_W    = adc_dds_pkg::DATA_W,
  parameter int FCW_W     = adc_dds_pkg::FCW_W,
  parameter int GATE_LOG2 = 20
) (
  input  logic           clk,
  input  logic           rst,
  adc_freq_meter_if.slave bus
);
  import adc_dds_pkg::*;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_GATE = GATE;
  localparam logic [1:0] S_DONE = DONE;
  localparam int         SH     = FCW_W - GATE_LOG2;

  logic [1:0]           state;
  logic [GATE_LOG2-1:0] gcnt;
  logic [GATE_LOG2-1:0] cnt;
  logic                 rise;
  logic [FCW_W-1:0]     fcw_nxt;
  logic                 mv_nxt;

  hyst_cmp #(.DATA_W(DATA_W)) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .adc_data  (bus.adc_data),
    .adc_valid (bus.adc_valid),
    .thr_hi    (bus.thr_hi),
    .thr_lo    (bus.thr_lo),
    .rise      (rise),
    .cfg_err   (bus.cfg_err)
  );

  assign bus.busy = (state == S_GATE);

`ifdef ADC_FMETER_AVG_EN
  logic [GATE_LOG2-1:0] hist [3];
  logic [1:0]           ndone;
  logic [GATE_LOG2+1:0] sum;

  assign sum = {2'b00, cnt} + {2'b00, hist[0]}
             + {2'b00, hist[1]} + {2'b00, hist[2]};
  assign fcw_nxt = FCW_W'(cnt2fcw(FCW_W'(sum), SH - 2));
  // Strobe only once four real gates are in the window
  assign mv_nxt  = (ndone == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
      ndone   <= '0;
    end else if (state == S_DONE) begin
      hist[0] <= cnt;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      if (ndone != 2'd3)
        ndone <= ndone + 2'd1;
    end
  end
`else
  assign fcw_nxt = FCW_W'(cnt2fcw(FCW_W'(cnt), SH));
  assign mv_nxt  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      gcnt           <= '0;
      cnt            <= '0;
      bus.fcword_est <= '0;
      bus.edge_cnt   <= '0;
      bus.meas_valid <= 1'b0;
      bus.sig_lost   <= 1'b0;
    end else begin
      bus.meas_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start || bus.cont)
            state <= S_GATE;
        end
        S_GATE: begin
          gcnt <= gcnt + 1'b1;
          if (rise)
            cnt <= cnt + 1'b1;
          if (&gcnt)
            state <= S_DONE;
        end
        S_DONE: begin
          bus.edge_cnt   <= cnt;
          bus.sig_lost   <= (cnt == '0);
          bus.fcword_est <= fcw_nxt;
          bus.meas_valid <= mv_nxt;
          cnt            <= '0;
          state          <= bus.cont ? S_GATE : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_freq_meter.sv
// Self-checking bench for adc_freq_meter with a 1024-clock gate.
// Table rows plus directed reset and continuous-mode sequences.
module tb_adc_freq_meter;

  localparam int GL = 10;
  localparam int GN = 1 << GL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_freq_meter_if #(.DATA_W(10), .FCW_W(32), .GATE_LOG2(GL)) bus ();

  adc_freq_meter #(.DATA_W(10), .FCW_W(32), .GATE_LOG2(GL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int mode;
    int hi;
    int lo;
    int exp;
    bit cfg;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          mode   = 0;
  int          cyc    = 0;
  int          mcount = 0;
  bit          mhi    = 1'b0;
  logic [31:0] acc    = '0;
  vec_t        tbl [8];

  function automatic logic [9:0] wave(int m, int c);
    int p;
    p = c % 64;
    case (m)
      0: return (p < 32) ? 10'd1023 : 10'd0;
      1: return 10'd512;
      2: if (p < 32) return (c % 2 != 0) ? 10'd450 : 10'd1023;
         else        return (c % 2 != 0) ? 10'd550 : 10'd0;
      3: return 10'($urandom_range(0, 1023));
      4: return acc[31:22];
      5: if (p < 16)      return 10'd1023;
         else if (p < 32) return 10'd650;
         else if (p < 48) return 10'd1023;
         else             return 10'd0;
      6: return (p < 32) ? 10'd600 : 10'd400;
      default: return 10'd0;
    endcase
  endfunction

  // Present one sample, advance the reference comparator, clock once
  task automatic step(input bit counted);
    int lo;
    bus.adc_valid = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.adc_data  = wave(mode, cyc);
    acc = acc + 32'h0200_0000;
    cyc++;
    if (rst) begin
      mhi = 1'b0;
    end else if (bus.adc_valid) begin
      lo = (bus.thr_lo > bus.thr_hi) ? int'(bus.thr_hi) : int'(bus.thr_lo);
      if (!mhi && int'(bus.adc_data) >= int'(bus.thr_hi)) begin
        mhi = 1'b1;
        if (counted) mcount++;
      end else if (mhi && int'(bus.adc_data) <= lo) begin
        mhi = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_fcw"},  64'(bus.fcword_est), 64'd0);
    chk({nm, "_cnt"},  64'(bus.edge_cnt),   64'd0);
    chk({nm, "_mv"},   64'(bus.meas_valid), 64'd0);
    chk({nm, "_busy"}, 64'(bus.busy),       64'd0);
    chk({nm, "_lost"}, 64'(bus.sig_lost),   64'd0);
    chk({nm, "_cfg"},  64'(bus.cfg_err),    64'd0);
  endtask

  task automatic measure(input string nm, input int exp);
    int e;
    bus.start = 1'b1;
    step(1'b0);
    bus.start = 1'b0;
    chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
    mcount = 0;
    for (int i = 0; i < GN; i++) step(1'b1);
    chk({nm, "_early"}, 64'(bus.meas_valid), 64'd0);
    step(1'b0);
    e = (exp < 0) ? mcount : exp;
    chk({nm, "_mv"},   64'(bus.meas_valid), 64'd1);
    chk({nm, "_cnt"},  64'(bus.edge_cnt),   64'(e));
    chk({nm, "_fcw"},  64'(bus.fcword_est), 64'(e) << (32 - GL));
    chk({nm, "_lost"}, 64'(bus.sig_lost),   64'(e == 0));
    step(1'b0);
    chk({nm, "_mv_off"}, 64'(bus.meas_valid), 64'd0);
  endtask

  initial begin
    int seen;
    tbl[0] = '{0, 600, 400, 16, 1'b0};
    tbl[1] = '{4, 600, 400, 8, 1'b0};
    tbl[2] = '{1, 600, 400, 0, 1'b0};
    tbl[3] = '{2, 600, 400, 16, 1'b0};
    tbl[4] = '{3, -1, -1, -1, 1'b0};
    tbl[5] = '{3, -1, -1, -1, 1'b0};
    tbl[6] = '{6, 600, 400, 16, 1'b0};
    tbl[7] = '{5, 600, 700, 16, 1'b1};

    bus.start  = 1'b0;
    bus.cont   = 1'b0;
    bus.thr_hi = 10'd600;
    bus.thr_lo = 10'd400;
    repeat (3) step(1'b0);
    chk_zero("reset");
    rst = 1'b0;
    step(1'b0);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    foreach (tbl[r]) begin
      mode = tbl[r].mode;
      if (tbl[r].hi < 0) begin
        bus.thr_hi = 10'($urandom_range(300, 900));
        bus.thr_lo = 10'($urandom_range(0, int'(bus.thr_hi)));
      end else begin
        bus.thr_hi = 10'(tbl[r].hi);
        bus.thr_lo = 10'(tbl[r].lo);
      end
      repeat (130) step(1'b0);
      measure($sformatf("row%0d", r), tbl[r].exp);
      chk($sformatf("row%0d_cfg", r), 64'(bus.cfg_err), 64'(tbl[r].cfg));
    end

    // Reset in the middle of a gate drops the partial count silently
    mode = 0;
    bus.thr_hi = 10'd600;
    bus.thr_lo = 10'd400;
    repeat (70) step(1'b0);
    bus.start = 1'b1;
    step(1'b0);
    bus.start = 1'b0;
    repeat (500) step(1'b1);
    rst = 1'b1;
    step(1'b0);
    chk_zero("midrst");
    rst = 1'b0;
    seen = 0;
    repeat (1100) begin
      step(1'b0);
      if (bus.meas_valid) seen++;
    end
    chk("midrst_no_mv", 64'(seen), 64'd0);
    measure("after_rst", 16);

    // Continuous mode with stray start pulses during the gate
    bus.cont = 1'b1;
    step(1'b0);
    for (int g = 0; g < 2; g++) begin
      mcount = 0;
      for (int i = 0; i < GN; i++) begin
        bus.start = (i == 100 || i == 700);
        step(1'b1);
      end
      bus.start = 1'b0;
      chk($sformatf("cont%0d_early", g), 64'(bus.meas_valid), 64'd0);
      if (g == 1) bus.cont = 1'b0;
      step(1'b0);
      chk($sformatf("cont%0d_mv", g),   64'(bus.meas_valid), 64'd1);
      chk($sformatf("cont%0d_cnt", g),  64'(bus.edge_cnt),   64'd16);
      chk($sformatf("cont%0d_fcw", g),  64'(bus.fcword_est), 64'h0400_0000);
      chk($sformatf("cont%0d_model", g), 64'(mcount),        64'd16);
      chk($sformatf("cont%0d_busy", g), 64'(bus.busy),       64'(g == 0));
    end
    step(1'b0);
    chk("cont_end_mv", 64'(bus.meas_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
